// File: rtl/apb_requester.sv
// APB3 requester: converts single-beat host commands into APB SETUP/ACCESS
// transfers, returns one response per command and aborts a transfer whose
// completer keeps pready low for too long.
//
// Handshakes: cmd_* and rsp_* are valid/ready pairs; a beat transfers on a
// rising edge where valid and ready are both high. Once raised, rsp_vld_o and
// the response fields hold until rsp_rdy_i takes them. cmd_rdy_o does not
// depend on cmd_vld_i.
module apb_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        pclk_i,
  input  logic        prst_i,
  input  logic        cmd_vld_i,
  output logic        cmd_rdy_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_vld_o,
  input  logic        rsp_rdy_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic [31:0] paddr_o,
  output logic        pwrite_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  output logic [1:0]  dbg_state_o
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic          TMO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          write_q, write_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;
  logic          tmo_hit;

  // Final wait cycle: the counter has already seen TIMEOUT_CYCLES-1 stalls.
  assign tmo_hit = TMO_EN && (cnt_q == CNT_LAST);

  // State register and datapath registers; reset drops any transfer in flight.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic: latch command in IDLE, capture response in ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (cmd_vld_i) begin
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          write_d = cmd_write_i;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          // A completion in the timeout cycle still counts as normal.
          rdata_d = write_q ? 32'h0 : prdata_i;
          err_d   = pslverr_i;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (tmo_hit) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_rdy_o     = (state_q == IDLE) && !prst_i;
  assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o     = (state_q == ACCESS);
  assign rsp_vld_o     = (state_q == RESP);
  assign paddr_o       = addr_q;
  assign pwdata_o      = wdata_q;
  assign pwrite_o      = write_q;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = tmo_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed and randomized bench for apb_requester with a short timeout.
module tb_apb_requester;

  localparam int T = 4;

  // Clock and reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_vld_i = 1'b0, cmd_write_i = 1'b0;
  logic [31:0] cmd_addr_i = '0, cmd_wdata_i = '0;
  logic        cmd_rdy_o, rsp_vld_o, rsp_err_o, rsp_timeout_o;
  logic        rsp_rdy_i = 1'b0;
  logic [31:0] rsp_rdata_o, paddr_o, pwdata_o;
  logic        pwrite_o, psel_o, penable_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0, pslverr_i = 1'b0;
  logic [1:0]  dbg_state_o;

  apb_requester #(.TIMEOUT_CYCLES(T)) dut (
    .pclk_i(clk), .prst_i(rst),
    .cmd_vld_i(cmd_vld_i), .cmd_rdy_o(cmd_rdy_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .paddr_o(paddr_o), .pwrite_o(pwrite_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i),
    .pslverr_i(pslverr_i), .dbg_state_o(dbg_state_o)
  );

  // Scoreboard: {timeout, err, rdata}
  logic [33:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: one command with a completer inserting `waits` wait states.
  // waits >= T means the completer never answers within the timeout window.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] rdata, input logic err,
                         input logic noise, input int hold);
    logic        tmo;
    int          n_acc;
    logic [33:0] e;
    logic [1:0]  st;
    tmo   = (waits >= T);
    n_acc = tmo ? T : waits + 1;
    exp_q.push_back(tmo ? {1'b1, 1'b1, 32'h0} : {1'b0, err, (wr ? 32'h0 : rdata)});

    check("idle_cmd_rdy", {31'b0, cmd_rdy_o}, 32'd1);
    check("idle_psel", {30'b0, psel_o, penable_o}, 32'd0);
    cmd_vld_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wdata;
    step();
    cmd_vld_i = 1'b0; cmd_write_i = ~wr; cmd_addr_i = $urandom; cmd_wdata_i = $urandom;
    // SETUP
    check("setup_sel_en_rdy", {29'b0, psel_o, penable_o, cmd_rdy_o}, 32'b100);
    check("setup_paddr", paddr_o, addr);
    check("setup_pwrite", {31'b0, pwrite_o}, {31'b0, wr});
    check("setup_pwdata", pwdata_o, wdata);
    for (int i = 0; i < n_acc; i++) begin
      step();
      check("access_sel_en", {30'b0, psel_o, penable_o}, 32'b11);
      check("access_paddr", paddr_o, addr);
      check("access_pwdata", pwdata_o, wdata);
      check("access_no_rsp", {31'b0, rsp_vld_o}, 32'd0);
      pready_i  = (i == waits);
      prdata_i  = (i == waits) ? rdata : $urandom;
      pslverr_i = (i == waits) ? err : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    step();
    pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = $urandom;
    e = exp_q.pop_front();
    check("resp_vld", {31'b0, rsp_vld_o}, 32'd1);
    check("resp_sel_en", {30'b0, psel_o, penable_o}, 32'd0);
    check("resp_rdata", rsp_rdata_o, e[31:0]);
    check("resp_err", {31'b0, rsp_err_o}, {31'b0, e[32]});
    check("resp_timeout", {31'b0, rsp_timeout_o}, {31'b0, e[33]});
    check("resp_paddr_hold", paddr_o, addr);
    st = dbg_state_o;
    for (int k = 0; k < hold; k++) begin
      rsp_rdy_i = 1'b0; cmd_vld_i = 1'b1; cmd_addr_i = $urandom;
      step();
      check("hold_vld_rdy", {30'b0, rsp_vld_o, cmd_rdy_o}, 32'b10);
      check("hold_rdata", rsp_rdata_o, e[31:0]);
      check("hold_flags", {30'b0, rsp_err_o, rsp_timeout_o}, {30'b0, e[32], e[33]});
      check("hold_psel", {31'b0, psel_o}, 32'd0);
      check("hold_state", {30'b0, dbg_state_o}, {30'b0, st});
    end
    cmd_vld_i = 1'b0; rsp_rdy_i = 1'b1;
    step();
    rsp_rdy_i = 1'b0;
    check("back_idle", {29'b0, cmd_rdy_o, rsp_vld_o, psel_o}, 32'b100);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_rdy", {31'b0, cmd_rdy_o}, 32'd0);
    check("rst_ctl", {26'b0, psel_o, penable_o, pwrite_o, rsp_vld_o, rsp_err_o, rsp_timeout_o}, 32'd0);
    check("rst_paddr", paddr_o, 32'd0);
    check("rst_pwdata", pwdata_o, 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'd0);
    #2 rst = 1'b0;
    step();
    check("post_rst_cmd_rdy", {31'b0, cmd_rdy_o}, 32'd1);

    // Directed cases
    run_cmd(1'b1, 32'h14, 32'h0000_0301, 0, 32'h1234_5678, 1'b0, 1'b0, 0);
    run_cmd(1'b0, 32'h10, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    run_cmd(1'b0, 32'h18, 32'h0, 2, 32'hCAFE_0001, 1'b1, 1'b0, 0);
    run_cmd(1'b0, 32'h1C, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 1'b1, 0);
    run_cmd(1'b0, 32'h20, 32'h0, 9, 32'h5555_AAAA, 1'b0, 1'b0, 0);
    run_cmd(1'b1, 32'h24, 32'hAAAA_0000, T - 1, 32'h0, 1'b0, 1'b0, 0);
    run_cmd(1'b0, 32'h28, 32'h0, 1, 32'h0000_BEEF, 1'b0, 1'b0, 10);
    run_cmd(1'b1, 32'h2C, 32'h0000_0042, 0, 32'h0, 1'b1, 1'b0, 0);

    // Reset in the middle of ACCESS
    cmd_vld_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'h30;
    step();
    cmd_vld_i = 1'b0;
    step();
    check("pre_rst_access", {30'b0, psel_o, penable_o}, 32'b11);
    #2 rst = 1'b1;
    #1;
    check("midrst_sel_en", {30'b0, psel_o, penable_o}, 32'd0);
    check("midrst_vld_rdy", {30'b0, rsp_vld_o, cmd_rdy_o}, 32'd0);
    step();
    #2 rst = 1'b0;
    step();
    check("after_rst", {29'b0, cmd_rdy_o, rsp_vld_o, psel_o}, 32'b100);
    step();
    check("after_rst_no_rsp", {31'b0, rsp_vld_o}, 32'd0);
    run_cmd(1'b0, 32'h34, 32'h0, 1, 32'h0F0F_0F0F, 1'b0, 1'b0, 0);

    // Randomized commands
    for (int n = 0; n < 30; n++) begin
      run_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 6),
              $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3));
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
